dot_acc_seq: RTL and testbench
==============================

Name: dot_acc_seq

Overview:
- Sequencing and accumulation stage wrapped around the 8-bit float multiply-accumulate datapath.
- Accepts a stream of (a, b) element pairs over a valid/ready handshake and drives them onto the MAC multiplicand inputs.
- Feeds its own accumulator register into the MAC addend input and captures the MAC sum each accepted beat.
- On the last element of a vector, emits the dot-product result over a valid/ready output handshake.
- The MAC stays external and purely combinational; this block owns all state. Values are opaque 8-bit float codes here, and no float arithmetic is done in this block.

Parameters:
- MAX_LEN, 16, maximum elements per vector before forced termination (2..255).
- CNT_W, 8, width of element counter and out_len.
- ACC_INIT, 8'h00, accumulator start code (+0.0).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous abort: discard partial vector, acc<=ACC_INIT, count<=0; does not touch a pending output
- in_valid  in  1  element pair valid
- in_ready  out  1  element pair accepted when in_valid&&in_ready
- in_a  in  8  multiplicand A code
- in_b  in  8  multiplicand B code
- in_last  in  1  final element of current vector
- mac_a  out  8  to MAC A (=in_a, combinational)
- mac_b  out  8  to MAC B (=in_b, combinational)
- mac_c  out  8  to MAC C (=acc register)
- mac_d  in  8  MAC result C + A*B (combinational from mac_a/b/c)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  8  dot-product result code
- out_len  out  CNT_W  number of elements in result vector
- out_ovf  out  1  result was forced by MAX_LEN, not by in_last

Behaviour:
- Reset (async, immediate): acc=ACC_INIT, count=0, out_valid=0, out_data=0, out_len=0, out_ovf=0. in_ready=1 once rst deasserts. Reset mid-vector discards it entirely.
- in_ready = !out_valid || out_ready (combinational). Result register is single-entry; no skid.
- Accept = in_valid && in_ready.
- On accept, not terminating: acc<=mac_d, count<=count+1.
- Terminating accept occurs when in_last, or when count==MAX_LEN-1:
  - out_data<=mac_d, out_len<=count+1, out_ovf<=!in_last, out_valid<=1;
  - acc<=ACC_INIT, count<=0.
  - in_last together with count==MAX_LEN-1 gives out_ovf=0.
- Latency: out_valid rises on the clock edge that accepts the terminating element.
- No accept (bubble, or in_valid with in_ready=0): acc and count hold. mac_c is always the current acc.
- Output handshake: out_valid && out_ready clears out_valid unless the same cycle has a terminating accept, which reloads the result; out_valid stays 1.
- Output stability: while out_valid && !out_ready, out_data/out_len/out_ovf hold and in_ready=0.
- clr: takes priority over accept on acc/count (the element is dropped). Output register behaves as if no terminating accept occurred.
- Single-element vector (in_last on first beat): result = mac_d with mac_c=ACC_INIT, out_len=1.
- Counter never wraps: termination at MAX_LEN guarantees count<MAX_LEN.
- Implicit states: ACCUM (count>0), IDLE (count==0), HOLD (out_valid && !out_ready). Implemented as registers, not a separate FSM encoding.

Test Plan (bench uses integer MAC stub: mac_d = (mac_c + mac_a*mac_b) mod 256):
- Reset: pulse rst asynchronously mid-cycle. Outputs go to out_valid=0, out_data=0, out_len=0, out_ovf=0, mac_c=0x00 without waiting for a clock edge; in_ready=1 after release.
- Basic vector: a={1,2,3}, b={4,5,6}, in_last on beat 3 with no gaps. out_valid=1 right after the 3rd accept edge, out_data=0x20, out_len=3, out_ovf=0.
- Backpressure and restart: hold out_ready=0 for 5 cycles with in_valid=1. Required: in_ready=0 and out_data stays 0x20. Then release and send a={2}, b={3}, last=1; result out_data=0x06 (acc restarted from 0), out_len=1.
- Simultaneous: pending result while out_ready=1 and the terminating element of the next vector is accepted the same cycle. out_valid stays 1 with the new value and no result is lost. Check by scoreboard over 100 random vectors with random bubbles and backpressure.
- Overflow: MAX_LEN=4, send 4 elements a=b=1 with in_last=0. Required: out_data=0x04, out_len=4, out_ovf=1; the 5th element starts a new vector from 0.
- Abort: reset mid-vector after 2 elements (a=b=3). Required: acc=0, no output; then a={1}, b={7}, last gives out_data=0x07. Repeat using clr instead of rst; same result, and a pending output is untouched by clr.

Source files
------------

// File: rtl/dot_acc_seq.sv
// dot_acc_seq: sequencing and accumulation wrapper around an external
// combinational 8-bit float MAC. Element pairs stream in over a valid/ready
// handshake. The accumulator feeds the MAC addend and captures the MAC sum
// on every accepted beat. A vector ends on in_last, or is forced to end
// after MAX_LEN elements. Each finished vector is presented on a
// single-entry valid/ready result register.
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   clr                  sync abort of the partial vector (pending result kept)
//   in_valid/in_ready    element pair handshake
//   in_a, in_b, in_last  element pair codes, end-of-vector marker
//   mac_a, mac_b, mac_c  MAC operands (A, B pass-through; C = accumulator)
//   mac_d                MAC result C + A*B
//   out_valid/out_ready  result handshake
//   out_data             dot-product result code
//   out_len              element count of the result vector
//   out_ovf              vector was terminated by MAX_LEN rather than in_last
module dot_acc_seq #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned CNT_W    = 8,
  parameter logic [7:0]  ACC_INIT = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic [7:0]       mac_c,
  input  logic [7:0]       mac_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] out_len,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [CNT_W-1:0] out_len_q, out_len_d;
  logic             out_ovf_q, out_ovf_d;

  logic in_rdy;
  logic accept;
  logic term;

  // The result register is single-entry: accept only if it is empty or draining.
  assign in_rdy = !out_valid_q || out_ready;
  assign accept = in_valid && in_rdy;
  assign term   = in_last || (cnt_q == CNT_LAST);

  assign in_ready  = in_rdy;
  assign mac_a     = in_a;
  assign mac_b     = in_b;
  assign mac_c     = acc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_len   = out_len_q;
  assign out_ovf   = out_ovf_q;

  // Next-state: accumulate, terminate/reload result, or abort on clr.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      // Abort drops any element offered this cycle; the result register only drains.
      acc_d = ACC_INIT;
      cnt_d = '0;
    end else if (accept) begin
      if (term) begin
        acc_d       = ACC_INIT;
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = mac_d;
        out_len_d   = cnt_q + CNT_W'(1);
        out_ovf_d   = !in_last;
      end else begin
        acc_d = mac_d;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= ACC_INIT;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_len_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_dot_acc_seq.sv
// Testbench for dot_acc_seq with an integer MAC stub. Directed checks cover
// reset, basic vector, backpressure, overflow and abort. A randomized phase
// then uses a dot-product reference model feeding a scoreboard queue, which
// a separate monitor drains on each output handshake.
module tb_dot_acc_seq;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = 8'h00;
  logic [7:0]       in_b = 8'h00;
  logic             in_last = 1'b0;
  logic [7:0]       mac_a, mac_b, mac_c, mac_d;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic [CNT_W-1:0] out_len;
  logic             out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  // Expected results: {ovf, len, data}
  logic [16:0] exp_q[$];
  bit          drv_done = 1'b0;

  always #5 clk = ~clk;

  // Integer MAC stub, truncated to 8 bits.
  assign mac_d = 8'(mac_c + mac_a * mac_b);

  dot_acc_seq #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .ACC_INIT(8'h00)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_len(out_len), .out_ovf(out_ovf)
  );

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Offer one beat starting at a negedge, hold until accepted; returns at posedge+1.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!ok && n < 50) begin
      #4 ok = in_ready;
      @(posedge clk);
      if (!ok) @(negedge clk);
      n++;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got no accept want accept");
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic chk_out(input string name, input int v, input int d, input int l, input int o);
    chk({name, "_valid"}, int'(out_valid), v);
    chk({name, "_data"},  int'(out_data),  d);
    chk({name, "_len"},   int'(out_len),   l);
    chk({name, "_ovf"},   int'(out_ovf),   o);
  endtask

  // Random phase driver with a sum-of-products reference model.
  task automatic rand_driver();
    int cur_sum;
    int cur_len;
    int len;
    bit ok;
    int n;
    cur_sum = 0;
    cur_len = 0;
    for (int v = 0; v < 100; v++) begin
      len = int'($urandom_range(1, 6));
      for (int e = 0; e < len; e++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
        in_last = (e == len - 1);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
          #4 ok = in_ready;
          @(posedge clk);
          if (!ok) @(negedge clk);
          n++;
        end
        if (!ok) begin
          n_cmp++; n_err++;
          $display("FAIL rand_accept_timeout: got no accept want accept");
        end else begin
          cur_sum += int'(in_a) * int'(in_b);
          cur_len++;
          if (in_last || cur_len == int'(MAX_LEN)) begin
            exp_q.push_back({!in_last, 8'(cur_len), 8'(cur_sum)});
            cur_sum = 0;
            cur_len = 0;
          end
        end
        #1 in_valid = 1'b0;
      end
    end
    drv_done = 1'b1;
  endtask

  // Random out_ready plus scoreboard monitor on the output handshake.
  task automatic rand_monitor();
    logic [16:0] e;
    int cyc;
    cyc = 0;
    while (!(drv_done && exp_q.size() == 0) && cyc < 20000) begin
      @(negedge clk);
      out_ready = drv_done ? 1'b1 : ($urandom_range(0, 3) != 0);
      #4;
      if (out_valid && !out_ready) chk("hold_in_ready", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_unexpected: got result 0x%0h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", int'(out_data), int'(e[7:0]));
          chk("sb_len",  int'(out_len),  int'(e[15:8]));
          chk("sb_ovf",  int'(out_ovf),  int'(e[16]));
        end
      end
      cyc++;
    end
    if (cyc >= 20000) begin
      n_cmp++; n_err++;
      $display("FAIL sb_drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    // Reset values and in_ready after release.
    #13 rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_mac_c", int'(mac_c), 0);
    chk_out("rst", 0, 0, 0, 0);

    // Basic vector, result held by out_ready=0.
    out_ready = 1'b0;
    send(8'd1, 8'd4, 1'b0);
    chk("basic_no_early", int'(out_valid), 0);
    send(8'd2, 8'd5, 1'b0);
    send(8'd3, 8'd6, 1'b1);
    chk_out("basic", 1, 8'h20, 3, 0);

    // Backpressure: in_valid high, result pending.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b0;
    repeat (5) begin
      #4 chk("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1 chk("bp_data", int'(out_data), 8'h20);
      chk("bp_valid", int'(out_valid), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Release: drain old result and reload on the same edge.
    out_ready = 1'b1;
    send(8'd2, 8'd3, 1'b1);
    chk_out("restart", 1, 8'h06, 1, 0);

    // Forced termination at MAX_LEN.
    repeat (4) send(8'd1, 8'd1, 1'b0);
    chk_out("ovf", 1, 8'h04, 4, 1);
    send(8'd1, 8'd1, 1'b1);
    chk_out("ovf_next", 1, 8'h01, 1, 0);
    repeat (3) send(8'd1, 8'd1, 1'b0);
    send(8'd2, 8'd2, 1'b1);
    chk_out("last_at_max", 1, 8'h07, 4, 0);

    // Abort via asynchronous reset mid-vector.
    send(8'd3, 8'd3, 1'b0);
    send(8'd3, 8'd3, 1'b0);
    chk("pre_rst_acc", int'(mac_c), 18);
    #3 rst = 1'b1;
    #1;
    chk("arst_mac_c", int'(mac_c), 0);
    chk_out("arst", 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 chk("arst_in_ready", int'(in_ready), 1);
    send(8'd1, 8'd7, 1'b1);
    chk_out("after_rst", 1, 8'h07, 1, 0);

    // Abort via clr mid-vector.
    send(8'd3, 8'd3, 1'b0);
    send(8'd3, 8'd3, 1'b0);
    chk("pre_clr_acc", int'(mac_c), 18);
    @(negedge clk); clr = 1'b1;
    @(posedge clk);
    #1 chk("clr_mac_c", int'(mac_c), 0);
    chk("clr_no_out", int'(out_valid), 0);
    @(negedge clk); clr = 1'b0;
    send(8'd1, 8'd7, 1'b1);
    chk_out("after_clr", 1, 8'h07, 1, 0);

    // clr leaves a pending result alone, and drops an offered terminating element.
    out_ready = 1'b0;
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_a = 8'd4; in_b = 8'd4; in_last = 1'b1;
    @(posedge clk);
    #1 chk_out("clr_pending", 1, 8'h07, 1, 0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk);
    #1 chk("clr_drop_valid", int'(out_valid), 0);
    chk("clr_drop_mac_c", int'(mac_c), 0);
    @(negedge clk); clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;

    // Randomized phase.
    fork
      rand_driver();
      rand_monitor();
    join
    #1 chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
